// File: rtl/sh1_pkg.sv
// Shared definitions for the SH-1 issue pipeline: ALU op codes, T-bit sources
// and the decoded-instruction record handed from decode to the issue stage.
package sh1_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_NOT = 4'b0101;
    localparam logic [3:0] ALU_SHL = 4'b0110;
    localparam logic [3:0] ALU_SHR = 4'b0111;
    localparam logic [3:0] ALU_SAR = 4'b1000;

    typedef enum logic [2:0] {
        TSRC_NONE,
        TSRC_OVF,
        TSRC_ZERO,
        TSRC_MSB,
        TSRC_LSB
    } tsrc_e;

    typedef enum logic [1:0] {
        BSEL_RM,
        BSEL_IMM,
        BSEL_ONE
    } bsel_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  dest;
        logic        a_is_rm;
        bsel_e       bsel;
        logic        rd_rn;
        logic        rd_rm;
        logic        we;
        tsrc_e       tsrc;
        logic        illegal;
        logic [31:0] imm;
    } dec_t;

    function automatic logic [31:0] sext8(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

endpackage

// File: rtl/sh_instr_decode.sv
// Combinational decode of a 16-bit SH-1 word into ALU op, operand selects,
// register read/write usage and the T-bit source.
module sh_instr_decode
    import sh1_pkg::*;
(
    input  logic [15:0] instr_i,
    output dec_t        dec_o
);

    dec_t d;

    always_comb begin
        d         = '0;
        d.op      = ALU_ADD;
        d.dest    = instr_i[11:8];
        d.bsel    = BSEL_RM;
        d.tsrc    = TSRC_NONE;
        d.imm     = sext8(instr_i[7:0]);
        casez (instr_i)
            16'b0011_????_????_1100: begin d.we = 1'b1; d.rd_rn = 1'b1; d.rd_rm = 1'b1; end
            16'b0011_????_????_1111: begin
                d.we = 1'b1; d.rd_rn = 1'b1; d.rd_rm = 1'b1; d.tsrc = TSRC_OVF;
            end
            16'b0111_????_????_????: begin d.we = 1'b1; d.rd_rn = 1'b1; d.bsel = BSEL_IMM; end
            16'b0011_????_????_1000: begin
                d.op = ALU_SUB; d.we = 1'b1; d.rd_rn = 1'b1; d.rd_rm = 1'b1;
            end
            // CMP/EQ reads both registers but never writes, so it cannot cause a hazard
            16'b0011_????_????_0000: begin
                d.op = ALU_SUB; d.rd_rn = 1'b1; d.rd_rm = 1'b1; d.tsrc = TSRC_ZERO;
            end
            16'b0010_????_????_1001: begin
                d.op = ALU_AND; d.we = 1'b1; d.rd_rn = 1'b1; d.rd_rm = 1'b1;
            end
            16'b0010_????_????_1010: begin
                d.op = ALU_XOR; d.we = 1'b1; d.rd_rn = 1'b1; d.rd_rm = 1'b1;
            end
            16'b0010_????_????_1011: begin
                d.op = ALU_OR; d.we = 1'b1; d.rd_rn = 1'b1; d.rd_rm = 1'b1;
            end
            16'b0110_????_????_0111: begin
                d.op = ALU_NOT; d.we = 1'b1; d.rd_rm = 1'b1; d.a_is_rm = 1'b1;
            end
            16'b0100_????_0000_0000: begin
                d.op = ALU_SHL; d.we = 1'b1; d.rd_rn = 1'b1; d.bsel = BSEL_ONE; d.tsrc = TSRC_MSB;
            end
            16'b0100_????_0000_0001: begin
                d.op = ALU_SHR; d.we = 1'b1; d.rd_rn = 1'b1; d.bsel = BSEL_ONE; d.tsrc = TSRC_LSB;
            end
            16'b0100_????_0010_0001: begin
                d.op = ALU_SAR; d.we = 1'b1; d.rd_rn = 1'b1; d.bsel = BSEL_ONE; d.tsrc = TSRC_LSB;
            end
            default: d.illegal = 1'b1;
        endcase
    end

    assign dec_o = d;

endmodule

// File: rtl/sh_alu_issue.sv
// Two-stage SH-1 issue/writeback pipeline: decode+operand read (D), ALU drive (EX),
// result and T-bit capture (WB), with EX-stage stall and WB-stage forwarding.
module sh_alu_issue
    import sh1_pkg::*;
#(
    parameter int   XLEN  = 32,
    parameter logic RST_T = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [15:0]     instr,
    output logic [3:0]      rf_ra_addr,
    input  logic [XLEN-1:0] rf_ra_data,
    output logic [3:0]      rf_rb_addr,
    input  logic [XLEN-1:0] rf_rb_data,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            alu_carry,
    input  logic            alu_overflow,
    output logic            wb_en,
    output logic [3:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            t_bit,
    output logic            illegal
);

    dec_t dec;

    logic            ex_vld_q, ex_we_q, ex_shout_q, ex_ill_q;
    logic            ex_vld_d, ex_we_d, ex_shout_d, ex_ill_d;
    logic [3:0]      ex_dest_q, ex_dest_d, alu_op_q, alu_op_d;
    tsrc_e           ex_tsrc_q, ex_tsrc_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic            wb_en_q, t_q;
    logic [3:0]      wb_addr_q;
    logic [XLEN-1:0] wb_data_q;

    logic            ex_hit, accept;
    logic [XLEN-1:0] rn_val, rm_val;
    logic            unused_carry;

    assign unused_carry = alu_carry;

    sh_instr_decode u_decode (
        .instr_i (instr),
        .dec_o   (dec)
    );

    assign rf_ra_addr = instr[11:8];
    assign rf_rb_addr = instr[7:4];

    // A source still in EX has no result yet: hold the word one cycle so it forwards from WB.
    assign ex_hit = ex_vld_q && ex_we_q &&
                    ((dec.rd_rn && (ex_dest_q == rf_ra_addr)) ||
                     (dec.rd_rm && (ex_dest_q == rf_rb_addr)));
    assign instr_ready = rst_n && !ex_hit;
    assign accept      = instr_valid && instr_ready;

    assign rn_val = (wb_en_q && (wb_addr_q == rf_ra_addr)) ? wb_data_q : rf_ra_data;
    assign rm_val = (wb_en_q && (wb_addr_q == rf_rb_addr)) ? wb_data_q : rf_rb_data;

    always_comb begin
        ex_vld_d   = accept;
        ex_ill_d   = accept && dec.illegal;
        ex_we_d    = 1'b0;
        ex_dest_d  = 4'd0;
        ex_tsrc_d  = TSRC_NONE;
        ex_shout_d = 1'b0;
        alu_op_d   = ALU_ADD;
        alu_a_d    = '0;
        alu_b_d    = '0;
        // Illegal words retire as bubbles so the ALU sees the idle ADD 0,0.
        if (accept && !dec.illegal) begin
            ex_we_d    = dec.we;
            ex_dest_d  = dec.dest;
            ex_tsrc_d  = dec.tsrc;
            ex_shout_d = (dec.tsrc == TSRC_MSB) ? rn_val[XLEN-1] : rn_val[0];
            alu_op_d   = dec.op;
            alu_a_d    = dec.a_is_rm ? rm_val : rn_val;
            case (dec.bsel)
                BSEL_IMM: alu_b_d = dec.imm;
                BSEL_ONE: alu_b_d = {{(XLEN-1){1'b0}}, 1'b1};
                default:  alu_b_d = rm_val;
            endcase
        end
    end

    // D -> EX boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld_q   <= 1'b0;
            ex_ill_q   <= 1'b0;
            ex_we_q    <= 1'b0;
            ex_dest_q  <= 4'd0;
            ex_tsrc_q  <= TSRC_NONE;
            ex_shout_q <= 1'b0;
            alu_op_q   <= ALU_ADD;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
        end else begin
            ex_vld_q   <= ex_vld_d;
            ex_ill_q   <= ex_ill_d;
            ex_we_q    <= ex_we_d;
            ex_dest_q  <= ex_dest_d;
            ex_tsrc_q  <= ex_tsrc_d;
            ex_shout_q <= ex_shout_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
        end
    end

    // EX -> WB boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_q   <= 1'b0;
            wb_addr_q <= 4'd0;
            wb_data_q <= '0;
            t_q       <= RST_T;
        end else begin
            wb_en_q <= ex_vld_q && ex_we_q;
            if (ex_vld_q && ex_we_q) begin
                wb_addr_q <= ex_dest_q;
                wb_data_q <= alu_result;
            end
            if (ex_vld_q) begin
                case (ex_tsrc_q)
                    TSRC_OVF:  t_q <= alu_overflow;
                    TSRC_ZERO: t_q <= alu_zero;
                    TSRC_MSB,
                    TSRC_LSB:  t_q <= ex_shout_q;
                    default:   t_q <= t_q;
                endcase
            end
        end
    end

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_op  = alu_op_q;
    assign illegal = ex_ill_q;
    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
    assign t_bit   = t_q;

endmodule
